mux4_share_arb: RTL and testbench
=================================

Name: mux4_share_arb

Overview:
- Two-requester arbiter that time-shares the 4-bit 2:1 select datapath (PNU_MUX2 bank) between requester A (drives mux input a) and requester B (drives mux input b).
- Generates the mux select, a one-hot grant to each requester and a busy flag.
- Round-robin on ties, with a hold limit so neither requester can starve the other.
- Sits directly in front of the mux select input; the mux datapath itself stays unchanged.

Parameters:
- MAX_HOLD, 8, max consecutive granted cycles for one requester while the other is requesting; legal range >= 1.
- CW, max(1, clog2(MAX_HOLD)), hold-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_a  input  1  requester A wants the datapath; held high for the whole transfer
- req_b  input  1  requester B wants the datapath; held high for the whole transfer
- gnt_a  output  1  A owns the datapath this cycle
- gnt_b  output  1  B owns the datapath this cycle
- sel  output  1  mux select: 0 passes a (i1), 1 passes b (i2)
- busy  output  1  gnt_a | gnt_b

Behaviour:
- All outputs are registered; busy is the OR of the registered grants.
- Reset (asynchronous, rst_n=0):
  - state=IDLE, gnt_a=0, gnt_b=0, sel=0, cnt=0, last=B, so A wins the first tie.
  - Reset mid-grant drops the grant immediately, with no completion cycle.
- Latency: a request seen at edge N is granted from edge N+1 when the datapath is free.
- States: IDLE, OWN_A, OWN_B.
- IDLE:
  - req_a&req_b -> grant the requester that is not `last`.
  - Only req_a -> OWN_A.
  - Only req_b -> OWN_B.
  - Neither -> stay in IDLE; sel holds its previous value (no toggle while idle).
- OWN_A (gnt_a=1, sel=0; OWN_B is symmetric with sel=1):
  - Release: req_a=0 -> if req_b then OWN_B on the same edge, else IDLE. No idle bubble on handover.
  - Preempt: req_a=1 & req_b=1 & cnt==MAX_HOLD-1 -> OWN_B.
  - Otherwise stay in OWN_A. cnt increments while req_b=1 and holds while req_b=0, saturating at MAX_HOLD-1, so a lone requester keeps ownership indefinitely.
- Every change of owner, and every entry into IDLE:
  - cnt clears to 0.
  - last updates to the requester just served.
- Handover updates gnt_a, gnt_b and sel on the same edge.
- gnt_a and gnt_b are never high together. sel always equals gnt_b whenever busy=1.
- MAX_HOLD=1 with both requesting: ownership alternates every cycle.
- A requester dropping and re-raising req in consecutive cycles while the other requests loses the tie next time (round-robin via `last`).
- No combinational path from req_* to any output.

Test Plan:
1. Reset with req_a=req_b=1 held, release rst_n at edge 0 -> gnt_a=1, sel=0 from edge 1; with MAX_HOLD=8, gnt_b=1, sel=1 from edge 9, then alternating every 8 cycles.
2. Only req_b high for 20 cycles -> gnt_b=1 from cycle 1 through cycle 20, no preemption, cnt stays 0; req_b low -> IDLE, busy=0 next edge, sel stays 1.
3. OWN_A with req_b=1, drop req_a at cycle 3 of ownership -> gnt_a=0, gnt_b=1 on the same edge, no cycle with busy=0.
4. MAX_HOLD=1, both requesting for 6 cycles -> grant pattern A,B,A,B,A,B; sel pattern 0,1,0,1,0,1; gnt_a&gnt_b never 1.
5. Assert rst_n=0 asynchronously mid-cycle during OWN_B -> gnt_b, busy and sel go to 0 before the next clock edge; after release with both requesting, A is granted first.
6. Drive a=4'hA and b=4'h5 into the mux bank under arbitration -> mux out equals 4'hA whenever gnt_a=1 and 4'h5 whenever gnt_b=1, checked over a 50-cycle random req sequence.

Source files
------------

// File: rtl/mux4_share_arb.sv
// Two-requester arbiter driving the select of the shared 4-bit 2:1 mux bank.
// Requester A owns input a (sel=0), requester B owns input b (sel=1); round-robin ties, bounded hold.
`timescale 1ns/1ps
module mux4_share_arb #(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic busy
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;

  // Handshake: req_x stays high for the whole transfer; gnt_x high means the
  // mux passes that requester's input this cycle. Grants change only on clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_B;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_a && (!req_b || last_q == LAST_B)) state_d = OWN_A;
        else if (req_b)                            state_d = OWN_B;
      end
      OWN_A: begin
        if (!req_a || (req_b && cnt_q == HOLD_LAST)) begin
          state_d = req_b ? OWN_B : IDLE;
          cnt_d   = '0;
          last_d  = LAST_A;
        end else if (req_b) begin
          // Only counts while the other side waits, so a lone owner never times out.
          cnt_d = cnt_q + CW'(1);
        end
      end
      OWN_B: begin
        if (!req_b || (req_a && cnt_q == HOLD_LAST)) begin
          state_d = req_a ? OWN_A : IDLE;
          cnt_d   = '0;
          last_d  = LAST_B;
        end else if (req_a) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // sel follows the new owner; it keeps its value while idle.
    case (state_d)
      OWN_A:   sel_d = 1'b0;
      OWN_B:   sel_d = 1'b1;
      default: sel_d = sel_q;
    endcase
  end

  assign gnt_a = (state_q == OWN_A);
  assign gnt_b = (state_q == OWN_B);
  assign sel   = sel_q;
  assign busy  = gnt_a | gnt_b;

endmodule

// File: tb/tb_mux4_share_arb.sv
// Directed bench for mux4_share_arb: default MAX_HOLD=8 instance plus a MAX_HOLD=1 instance.
`timescale 1ns/1ps
module tb_mux4_share_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0;
  logic req_b = 1'b0;
  logic gnt_a, gnt_b, sel, busy;
  logic gnt_a1, gnt_b1, sel1, busy1;
  logic [3:0] mux_a, mux_b, mux_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux4_share_arb #(.MAX_HOLD(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .busy(busy)
  );

  mux4_share_arb #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .sel(sel1), .busy(busy1)
  );

  // Behavioural stand-in for the 4-bit 2:1 mux bank.
  assign mux_out = sel ? mux_b : mux_a;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds reset across one edge with the caller's requests applied, checks the
  // reset outputs, then releases so the next edge is edge 1.
  task automatic apply_reset();
    rst_n = 1'b0;
    tick(1);
    check("rst_gnt_a", {3'b0, gnt_a}, 4'h0);
    check("rst_gnt_b", {3'b0, gnt_b}, 4'h0);
    check("rst_sel",   {3'b0, sel},   4'h0);
    check("rst_busy",  {3'b0, busy},  4'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic exp_b;
    mux_a = 4'hA;
    mux_b = 4'h5;

    // 1: both requesting out of reset, A first, swap every 8 cycles
    req_a = 1'b1;
    req_b = 1'b1;
    apply_reset();
    for (int k = 1; k <= 24; k++) begin
      tick(1);
      exp_b = (((k - 1) / 8) % 2) == 1;
      check("t1_gnt_a", {3'b0, gnt_a}, {3'b0, ~exp_b});
      check("t1_gnt_b", {3'b0, gnt_b}, {3'b0, exp_b});
      check("t1_sel",   {3'b0, sel},   {3'b0, exp_b});
    end

    // 2: lone B holds indefinitely, then idle keeps sel=1
    req_a = 1'b0;
    req_b = 1'b0;
    apply_reset();
    req_b = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      check("t2_gnt_b", {3'b0, gnt_b}, 4'h1);
      check("t2_gnt_a", {3'b0, gnt_a}, 4'h0);
    end
    req_b = 1'b0;
    tick(1);
    check("t2_idle_busy", {3'b0, busy}, 4'h0);
    check("t2_idle_sel",  {3'b0, sel},  4'h1);
    tick(2);
    check("t2_idle_sel_hold", {3'b0, sel}, 4'h1);

    // 3: release handover with no idle bubble
    apply_reset();
    req_a = 1'b1;
    tick(1);
    check("t3_own_a", {3'b0, gnt_a}, 4'h1);
    req_b = 1'b1;
    tick(2);
    check("t3_still_a", {3'b0, gnt_a}, 4'h1);
    req_a = 1'b0;
    tick(1);
    check("t3_ho_gnt_a", {3'b0, gnt_a}, 4'h0);
    check("t3_ho_gnt_b", {3'b0, gnt_b}, 4'h1);
    check("t3_ho_busy",  {3'b0, busy},  4'h1);
    check("t3_ho_sel",   {3'b0, sel},   4'h1);

    // 4: MAX_HOLD=1 alternates every cycle
    req_a = 1'b1;
    req_b = 1'b1;
    apply_reset();
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      exp_b = (k % 2) == 0;
      check("t4_gnt_a", {3'b0, gnt_a1}, {3'b0, ~exp_b});
      check("t4_gnt_b", {3'b0, gnt_b1}, {3'b0, exp_b});
      check("t4_sel",   {3'b0, sel1},   {3'b0, exp_b});
      check("t4_excl",  {3'b0, gnt_a1 & gnt_b1}, 4'h0);
    end

    // 5: asynchronous reset mid-cycle while B owns
    req_a = 1'b0;
    req_b = 1'b0;
    apply_reset();
    req_b = 1'b1;
    tick(1);
    check("t5_own_b", {3'b0, gnt_b}, 4'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_gnt_b", {3'b0, gnt_b}, 4'h0);
    check("t5_async_busy",  {3'b0, busy},  4'h0);
    check("t5_async_sel",   {3'b0, sel},   4'h0);
    req_a = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("t5_first_a", {3'b0, gnt_a}, 4'h1);
    check("t5_first_b", {3'b0, gnt_b}, 4'h0);

    // 6: mux output follows the grant over random request traffic
    req_a = 1'b0;
    req_b = 1'b0;
    apply_reset();
    for (int k = 0; k < 50; k++) begin
      req_a = 1'($urandom_range(0, 1));
      req_b = 1'($urandom_range(0, 1));
      tick(1);
      check("t6_excl", {3'b0, gnt_a & gnt_b}, 4'h0);
      if (gnt_a) check("t6_mux_a", mux_out, 4'hA);
      if (gnt_b) check("t6_mux_b", mux_out, 4'h5);
      if (busy)  check("t6_sel_gnt_b", {3'b0, sel}, {3'b0, gnt_b});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
